// File: rtl/rcon_seq.sv
// ---------------------------------------------------------------------------
// rcon_seq -- sequential AES round-constant generator.
//
// Emits the AES key-schedule round constants one word per valid/ready beat,
// starting from 01h and stepping with GF(2^8) xtime, instead of reading them
// from a fixed lookup table. AES-128/192/256 produce 10/8/7 words.
//
// Optional build macro:
//   RCON_REVERSE_EN  when defined, a start with rev=1 walks the sequence
//                    backwards (last constant first) for inverse key
//                    schedules. When undefined, rev is ignored and no reverse
//                    logic is built.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   launch a sequence; only looked at while idle
//   mode   in   [1:0] key size with start: 00 AES-128, 01 AES-192,
//               10 AES-256, 11 illegal (raises err)
//   rev    in   reverse-order request with start (RCON_REVERSE_EN only)
//   ready  in   consumer accepts the current word
//   valid  out  out/round/last carry a word
//   out    out  [DWORD-1:0] {rcon, zeros}
//   round  out  [3:0] index of the current word, 0..NR-1
//   last   out  current word is the final one
//   busy   out  a sequence is in progress
//   done   out  one-cycle pulse after the final handshake
//   err    out  one-cycle pulse after a start with mode=11
// ---------------------------------------------------------------------------
module rcon_seq #(
  parameter int              BYTE  = 8,
  parameter int              DWORD = 32,
  parameter logic [BYTE-1:0] POLY  = 8'h1b
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             rev,
  input  logic             ready,
  output logic             valid,
  output logic [DWORD-1:0] out,
  output logic [3:0]       round,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [BYTE-1:0] rcon_q,  rcon_d;
  logic [3:0]      round_q, round_d;
  logic [3:0]      nr_q,    nr_d;
  logic            done_q,  done_d;
  logic            err_q,   err_d;

  logic            run;
  logic            last_w;
  logic [3:0]      nr_sel;

  // Multiply by x in GF(2^8): shift left, fold the carried-out bit back in.
  function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] x);
    return {x[BYTE-2:0], 1'b0} ^ (x[BYTE-1] ? POLY : '0);
  endfunction

  // Number of round constants for each key size.
  always_comb begin
    case (mode)
      2'b00:   nr_sel = 4'd10;
      2'b01:   nr_sel = 4'd8;
      default: nr_sel = 4'd7;
    endcase
  end

`ifdef RCON_REVERSE_EN
  logic            rev_q, rev_d;
  logic [BYTE-1:0] rinit;

  // Divide by x: undo xtime. An odd value must have had the reduction
  // folded in, so strip POLY and restore the shifted-out top bit.
  function automatic logic [BYTE-1:0] inv_xtime(input logic [BYTE-1:0] x);
    return x[0] ? (((x ^ POLY) >> 1) | {1'b1, {(BYTE-1){1'b0}}}) : (x >> 1);
  endfunction

  // Final constant of each forward sequence, the reverse starting point.
  always_comb begin
    case (mode)
      2'b00:   rinit = BYTE'(8'h36);
      2'b01:   rinit = BYTE'(8'h80);
      default: rinit = BYTE'(8'h40);
    endcase
  end

  assign last_w = run & (rev_q ? (round_q == 4'd0) : (round_q == nr_q - 4'd1));
`else
  logic rev_unused;
  assign rev_unused = rev;
  assign last_w     = run & (round_q == nr_q - 4'd1);
`endif

  assign run = (state_q == S_RUN);

  // NOTE: every variable assigned in this block gets a default first so that
  // no path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    nr_d    = nr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef RCON_REVERSE_EN
    rev_d   = rev_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mode == 2'b11) begin
            err_d = 1'b1;
          end else begin
            state_d = S_RUN;
            nr_d    = nr_sel;
`ifdef RCON_REVERSE_EN
            rev_d   = rev;
            rcon_d  = rev ? rinit : BYTE'(1);
            round_d = rev ? nr_sel - 4'd1 : 4'd0;
`else
            rcon_d  = BYTE'(1);
            round_d = 4'd0;
`endif
          end
        end
      end
      S_RUN: begin
        // Nothing moves until the word is accepted, so out/round/last stay
        // stable while ready is low.
        if (ready) begin
          if (last_w) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
`ifdef RCON_REVERSE_EN
            rcon_d  = rev_q ? inv_xtime(rcon_q) : xtime(rcon_q);
            round_d = rev_q ? round_q - 4'd1 : round_q + 4'd1;
`else
            rcon_d  = xtime(rcon_q);
            round_d = round_q + 4'd1;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rcon_q  <= '0;
      round_q <= '0;
      nr_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef RCON_REVERSE_EN
      rev_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
      nr_q    <= nr_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef RCON_REVERSE_EN
      rev_q   <= rev_d;
`endif
    end
  end

  // Word fields are forced to zero whenever no word is being offered.
  assign valid = run;
  assign busy  = run;
  assign out   = run ? {rcon_q, {(DWORD-BYTE){1'b0}}} : '0;
  assign round = run ? round_q : 4'd0;
  assign last  = last_w;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_rcon_seq.sv
// ---------------------------------------------------------------------------
// tb_rcon_seq -- self-checking bench for rcon_seq.
//
// Inputs change on the falling edge; outputs are compared on the next
// falling edge. The reference model tracks only "which word of which
// sequence is on offer" and looks the value up in the published AES round
// constant list.
// ---------------------------------------------------------------------------
module tb_rcon_seq;

  logic        clk = 1'b0;
  logic        rst, start, rev, ready;
  logic [1:0]  mode;
  logic        valid, last, busy, done, err;
  logic [31:0] out;
  logic [3:0]  round;

  int errors = 0;
  int checks = 0;

  localparam logic [7:0] AES [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  rcon_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .rev   (rev),
    .ready (ready),
    .valid (valid),
    .out   (out),
    .round (round),
    .last  (last),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // {valid, out, round, last, busy, done, err} packed into 64 bits.
  function automatic logic [63:0] mk(bit v, logic [7:0] b, int r, bit l, bit bs, bit d, bit e);
    return {23'd0, v, b, 24'd0, 4'(r), l, bs, d, e};
  endfunction

  function automatic logic [63:0] dut_pack();
    return {23'd0, valid, out, round, last, busy, done, err};
  endfunction

  // ---------------- reference model ----------------
  bit m_busy, m_done, m_err, m_rev;
  int m_nr, m_k;   // m_k = number of words already accepted

  function automatic logic [63:0] exp_pack();
    int idx;
    if (!m_busy) return mk(0, 8'h00, 0, 0, 0, m_done, m_err);
    idx = m_rev ? (m_nr - 1 - m_k) : m_k;
    return mk(1, AES[idx], idx, (m_k == m_nr - 1), 1, 0, 0);
  endfunction

  task automatic model_update(input bit r, s, input logic [1:0] md, input bit rv, rd);
    if (r) begin
      m_busy = 0; m_done = 0; m_err = 0; m_rev = 0; m_nr = 0; m_k = 0;
    end else if (m_busy) begin
      m_done = 0;
      m_err  = 0;
      if (rd) begin
        if (m_k == m_nr - 1) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          m_k++;
        end
      end
    end else begin
      m_done = 0;
      m_err  = 0;
      if (s) begin
        if (md == 2'b11) begin
          m_err = 1;
        end else begin
          m_busy = 1;
          m_k    = 0;
          m_nr   = (md == 2'b00) ? 10 : (md == 2'b01) ? 8 : 7;
`ifdef RCON_REVERSE_EN
          m_rev  = rv;
`else
          m_rev  = 0;
`endif
        end
      end
    end
  endtask

  // One clock: drive at the falling edge, let the rising edge sample, then
  // compare against the model on the next falling edge.
  task automatic step(input bit r, s, input logic [1:0] md, input bit rv, rd, input string nm);
    rst = r; start = s; mode = md; rev = rv; ready = rd;
    @(posedge clk);
    model_update(r, s, md, rv, rd);
    @(negedge clk);
    check(nm, dut_pack(), exp_pack());
  endtask

  typedef struct {
    bit          r, s;
    logic [1:0]  md;
    bit          rv, rd;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; rev = 1'b0; ready = 1'b0;

    // ---------- table: reset, illegal mode, AES-256 with ready toggling ----
    tbl.push_back(vec_t'{1, 0, 2'd0, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0)});
    tbl.push_back(vec_t'{0, 1, 2'd3, 0, 1, mk(0, 8'h00, 0, 0, 0, 0, 1)});
    tbl.push_back(vec_t'{0, 0, 2'd0, 0, 1, mk(0, 8'h00, 0, 0, 0, 0, 0)});
    tbl.push_back(vec_t'{0, 1, 2'd2, 0, 0, mk(1, 8'h01, 0, 0, 1, 0, 0)});
    for (int k = 0; k < 7; k++) begin
      // start held high while busy must not disturb the sequence
      tbl.push_back(vec_t'{0, 1, 2'd0, 0, 1,
                    (k < 6) ? mk(1, AES[k+1], k+1, (k+1 == 6), 1, 0, 0)
                            : mk(0, 8'h00, 0, 0, 0, 1, 0)});
      if (k < 6)
        tbl.push_back(vec_t'{0, 0, 2'd0, 0, 0, mk(1, AES[k+1], k+1, (k+1 == 6), 1, 0, 0)});
    end
    tbl.push_back(vec_t'{0, 0, 2'd0, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0)});

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r; start = tbl[i].s; mode = tbl[i].md; rev = tbl[i].rv; ready = tbl[i].rd;
      @(posedge clk);
      model_update(tbl[i].r, tbl[i].s, tbl[i].md, tbl[i].rv, tbl[i].rd);
      @(negedge clk);
      check($sformatf("tbl%0d", i), dut_pack(), tbl[i].exp);
    end

    // ---------- mid-sequence reset after 4 AES-128 beats ----------
    step(0, 1, 2'd0, 0, 1, "a128_launch");
    for (int i = 0; i < 4; i++) step(0, 0, 2'd0, 0, 1, "a128_beat");
    check("pre_rst_word", {56'd0, out[31:24]}, 64'h10);
    step(1, 0, 2'd0, 0, 1, "midrun_rst");
    check("midrun_rst_lit", {27'd0, valid, busy, done, out}, 64'd0);
    step(0, 0, 2'd0, 0, 1, "post_rst_idle");
    check("post_rst_no_done", {63'd0, done}, 64'd0);
    step(0, 1, 2'd0, 0, 0, "restart");
    check("restart_word", {56'd0, out[31:24]}, 64'h01);
    step(1, 0, 2'd0, 0, 0, "reset2");

    // ---------- AES-128 full throughput ----------
    step(0, 1, 2'd0, 0, 1, "f128_launch");
    for (int i = 0; i < 10; i++) begin
      check($sformatf("f128_word%0d", i), {56'd0, out[31:24]}, {56'd0, AES[i]});
      check($sformatf("f128_last%0d", i), {63'd0, last}, {63'd0, (i == 9)});
      step(0, 0, 2'd0, 0, 1, "f128_beat");
    end
    // 11 cycles after start was sampled: launch + 10 beats
    check("f128_done", {63'd0, done}, 64'd1);

    // ---------- back-to-back AES-192, launched in the done cycle ----------
    for (int r = 0; r < 2; r++) begin
      step(0, 1, 2'd1, 0, 1, "b2b_launch");
      for (int i = 0; i < 8; i++) begin
        check($sformatf("b2b%0d_word%0d", r, i), {56'd0, out[31:24]}, {56'd0, AES[i]});
        step(0, 0, 2'd1, 0, 1, "b2b_beat");
      end
      check($sformatf("b2b%0d_done", r), {63'd0, done}, 64'd1);
    end
    step(0, 0, 2'd0, 0, 0, "b2b_idle");

    // ---------- reverse request (forward when the macro is off) ----------
    step(0, 1, 2'd0, 1, 1, "rev_launch");
    for (int i = 0; i < 10; i++) begin
`ifdef RCON_REVERSE_EN
      check($sformatf("rev_word%0d", i), {52'd0, out[31:24], round}, {52'd0, AES[9-i], 4'(9-i)});
`else
      check($sformatf("rev_word%0d", i), {52'd0, out[31:24], round}, {52'd0, AES[i], 4'(i)});
`endif
      step(0, 0, 2'd0, 1, 1, "rev_beat");
    end
    check("rev_done", {63'd0, done}, 64'd1);

    // ---------- randomized traffic against the model ----------
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) != 0),
           "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rcon_seq.md
Name: rcon_seq

Overview:
- Sequential AES round-constant generator; replaces the fixed 10-entry combinational Rcon lookup.
- Produces the Rcon words one per handshake beat, using GF(2^8) xtime from 01h rather than a table.
- Supports AES-128, AES-192 and AES-256 key schedules (10, 8 or 7 Rcon words).
- Feeds the key-expansion datapath through a valid/ready stream interface.

Parameters:
- BYTE, 8, field element width in bits; Rcon byte width.
- DWORD, 32, output word width; Rcon byte placed in bits [DWORD-1:DWORD-BYTE].
- POLY, 8'h1b, reduction constant applied by xtime; must be BYTE bits wide.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a new sequence; sampled only in IDLE.
- mode  input  2  key size, sampled with start: 00 AES-128 (NR=10), 01 AES-192 (NR=8), 10 AES-256 (NR=7), 11 illegal.
- rev  input  1  reverse-order request, sampled with start; used only when RCON_REVERSE_EN is defined, otherwise ignored.
- ready  input  1  consumer accepts the current word.
- valid  output  1  out, round and last are meaningful.
- out  output  DWORD  {rcon, (DWORD-BYTE) zeros}.
- round  output  4  index of the current word, 0..NR-1.
- last  output  1  current word is the final word of the sequence.
- busy  output  1  sequence in progress (state RUN).
- done  output  1  one-cycle pulse, cycle after the final handshake.
- err  output  1  one-cycle pulse, cycle after start is sampled with mode=11.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; rcon=0, round=0, nr=0; valid, last, busy, done, err=0; out=0.
  - Reset has priority over every other event, including a mid-sequence reset.
  - After a mid-sequence reset, no done pulse is issued.
- FSM states: IDLE, RUN.
- IDLE, start=1, mode!=11:
  - latch nr = 10/8/7; rcon=01h; round=0; go to RUN.
  - valid rises the next cycle; start-to-first-valid latency is 1 cycle.
- IDLE, start=1, mode=11: stay in IDLE; err=1 for exactly the next cycle.
- RUN:
  - valid=1, busy=1; out={rcon, zeros}; last = (round==nr-1).
- Accept = valid & ready.
  - Not last: rcon <= xtime(rcon), round <= round+1.
  - xtime(x) = x<<1 (BYTE bits) XOR (x[BYTE-1] ? POLY : 0).
  - Last: go to IDLE; valid=0 and done=1 the next cycle; done lasts one cycle.
- ready=0 with valid=1: out, round and last hold stable (AXI-stream rule). valid never drops before acceptance.
- Full-throughput rule:
  - ready held high gives one word per cycle, i.e. NR beats.
  - First start-to-done latency = NR+1 cycles.
- start while busy: ignored, no effect on the sequence.
- start in the same cycle done is high: accepted; done and the new launch may overlap, back-to-back sequences allowed.
- Sequences:
  - AES-128: 01,02,04,08,10,20,40,80,1b,36.
  - AES-192: first 8 of the AES-128 sequence.
  - AES-256: first 7 of the AES-128 sequence.
- round is 4 bits and never exceeds nr-1; no wrap-around occurs.

Optional Feature:
- Macro: RCON_REVERSE_EN.
- Defined, start with rev=1: the sequence runs backwards for inverse key schedules.
  - Initial rcon = 36h (AES-128), 80h (AES-192), 40h (AES-256); round starts at nr-1.
  - Each accepted non-last word: rcon <= inv_xtime(rcon), round <= round-1.
  - inv_xtime(x) = x[0] ? ((x XOR POLY)>>1) | 80h : x>>1.
  - last = (round==0).
  - Handshake, done and err timing are identical to the forward sequence.
- Undefined: rev input is ignored and the reverse logic is not synthesised; behaviour is forward-only.

Test Plan:
- Reset mid-RUN (AES-128, after 4 beats):
  - Next cycle: valid=0, busy=0, done=0, out=0.
  - A new start then begins again at 01h.
- AES-128 with ready=1 held:
  - out[31:24] = 01,02,04,08,10,20,40,80,1b,36 on 10 consecutive cycles.
  - last=1 only with 36h; done the cycle after.
- AES-256 with ready toggling 1,0,1,0:
  - 7 words 01..40, each held while ready=0.
  - round sequence 0..6; no duplicated or skipped beats.
- mode=11 start: err pulses one cycle, valid stays 0.
  - start asserted during RUN: the sequence is unaffected.
- Back-to-back: start asserted in the done cycle after AES-192 (01..80).
  - valid=1 with 01h on the following cycle; the 8-word AES-192 sequence repeats.
- RCON_REVERSE_EN defined, AES-128, rev=1:
  - Words 36,1b,80,40,20,10,08,04,02,01; round 9 down to 0; last with 01h.
  - Same stimulus with the macro undefined: forward sequence.
